ecsu_gen2: RTL and testbench

Parametrised second-generation environmental condition supervisory unit. It classifies registered weather sensor samples into four severity levels (NORMAL, CAUTION, SEVERE, EMERGENCY) with programmable thresholds. Escalation is immediate and may skip levels. De-escalation steps down one level at a time and only after a persistence window. EMERGENCY is exited only by an explicit pilot acknowledge; the block feeds the cockpit alert and autopilot mode logic.

---
 rtl/ecsu_gen2.sv | 149 ++++++++++++++
 tb/tb_ecsu_gen2.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ecsu_gen2.sv
// ---------------------------------------------------------------------------
// ecsu_gen2 - environmental condition supervisory unit, second generation.
//
// Each valid weather sample is classified into one of four severity levels:
// NORMAL(0), CAUTION(1), SEVERE(2) or EMERGENCY(3). Escalation is immediate
// and may skip levels. De-escalation drops one level per persistence window
// of PERSIST consecutive valid lower-level samples. EMERGENCY is left only
// through a pilot acknowledge, and always exits into SEVERE.
//
// Optional feature macro: ECSU_EVENT_CNT_EN
//   When defined, severe_events counts entries from state 0/1 into state 2/3
//   and saturates at all-ones. When undefined, severe_events is tied to 0.
//
// Ports:
//   CLK, RST_N               clock (rising edge), async active-low reset
//   sensor_valid             sample qualifier; all other inputs ignored when low
//   thunderstorm, wind,
//   visibility, temperature  sensor sample (temperature two's complement)
//   alert_ack                pilot acknowledge, only meaningful in EMERGENCY
//   ECSU_state               current severity level (registered)
//   severe_weather           ECSU_state >= SEVERE (registered)
//   emergency_landing_alert  ECSU_state == EMERGENCY (registered)
//   severe_events            severe-entry event count
// ---------------------------------------------------------------------------
module ecsu_gen2 #(
   parameter int WIND_W       = 6,
   parameter int TEMP_W       = 8,
   parameter int WIND_CAUTION = 10,
   parameter int WIND_SEVERE  = 15,
   parameter int WIND_EMERG   = 20,
   parameter int TEMP_SEVERE  = 35,
   parameter int TEMP_EMERG   = 40,
   parameter int PERSIST      = 4,
   parameter int EVT_W        = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              sensor_valid,
   input  logic              thunderstorm,
   input  logic [WIND_W-1:0] wind,
   input  logic [1:0]        visibility,
   input  logic [TEMP_W-1:0] temperature,
   input  logic              alert_ack,
   output logic [1:0]        ECSU_state,
   output logic              severe_weather,
   output logic              emergency_landing_alert,
   output logic [EVT_W-1:0]  severe_events
);

   localparam int CNT_W = $clog2(PERSIST) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST - 1);

   // Thresholds brought to the input widths: wind zero-extended, temperature
   // sign-extended so that the signed comparisons below are exact.
   localparam logic [WIND_W-1:0]        W_CAU  = WIND_W'(WIND_CAUTION);
   localparam logic [WIND_W-1:0]        W_SEV  = WIND_W'(WIND_SEVERE);
   localparam logic [WIND_W-1:0]        W_EMG  = WIND_W'(WIND_EMERG);
   localparam logic signed [TEMP_W-1:0] T_SEV  = TEMP_W'(TEMP_SEVERE);
   localparam logic signed [TEMP_W-1:0] T_SEVN = TEMP_W'(-TEMP_SEVERE);
   localparam logic signed [TEMP_W-1:0] T_EMG  = TEMP_W'(TEMP_EMERG);
   localparam logic signed [TEMP_W-1:0] T_EMGN = TEMP_W'(-TEMP_EMERG);

   typedef enum logic [1:0] {
      NORMAL    = 2'd0,
      CAUTION   = 2'd1,
      SEVERE    = 2'd2,
      EMERGENCY = 2'd3
   } state_t;

   state_t           state_q, state_d, level;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic signed [TEMP_W-1:0] temp_s;
   logic             emerg_c, severe_c, caution_c;

   assign temp_s = $signed(temperature);

   // ---- sample classification ----
   always_comb begin
      emerg_c   = (temp_s < T_EMGN) || (temp_s > T_EMG) || (wind > W_EMG);
      severe_c  = thunderstorm || (temp_s < T_SEVN) || (temp_s > T_SEV) ||
                  (wind > W_SEV) || (visibility == 2'd3);
      caution_c = (wind > W_CAU) || (visibility == 2'd1) || (visibility == 2'd2);
      level     = NORMAL;
      if (emerg_c)        level = EMERGENCY;
      else if (severe_c)  level = SEVERE;
      else if (caution_c) level = CAUTION;
   end

   // ---- next state / persistence counter ----
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (sensor_valid) begin
         if (state_q == EMERGENCY) begin
            // ack is sampled, never latched: it must coincide with a
            // non-emergency sample to release the alert.
            if (alert_ack && level != EMERGENCY) state_d = SEVERE;
            cnt_d = '0;
         end else if (level > state_q) begin
            state_d = level;
            cnt_d   = '0;
         end else if (level == state_q) begin
            cnt_d = '0;
         end else if (cnt_q >= CNT_LAST) begin
            // This sample completes the window: drop exactly one level.
            state_d = state_t'(state_q - 2'd1);
            cnt_d   = '0;
         end else begin
            // cnt_q < CNT_LAST here, so the increment cannot wrap.
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q                 <= NORMAL;
         cnt_q                   <= '0;
         severe_weather          <= 1'b0;
         emergency_landing_alert <= 1'b0;
      end else begin
         state_q                 <= state_d;
         cnt_q                   <= cnt_d;
         severe_weather          <= (state_d == SEVERE) || (state_d == EMERGENCY);
         emergency_landing_alert <= (state_d == EMERGENCY);
      end
   end

   assign ECSU_state = state_q;

`ifdef ECSU_EVENT_CNT_EN
   logic [EVT_W-1:0] evt_q;
   logic             enter_sev;

   // Only upward crossings of the SEVERE boundary count; 2<->3 moves do not.
   assign enter_sev = (state_q == NORMAL || state_q == CAUTION) &&
                      (state_d == SEVERE || state_d == EMERGENCY);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                       evt_q <= '0;
      else if (enter_sev && evt_q != '1) evt_q <= evt_q + 1'b1;
   end

   assign severe_events = evt_q;
`else
   assign severe_events = '0;
`endif

endmodule

// File: tb/tb_ecsu_gen2.sv
module tb_ecsu_gen2;

   localparam int WIND_W  = 6;
   localparam int TEMP_W  = 8;
   localparam int PERSIST = 4;
   localparam int EVT_W   = 8;

   logic              CLK = 1'b0;
   logic              RST_N;
   logic              sensor_valid, thunderstorm, alert_ack;
   logic [WIND_W-1:0] wind;
   logic [1:0]        visibility;
   logic [TEMP_W-1:0] temperature;
   logic [1:0]        ECSU_state;
   logic              severe_weather, emergency_landing_alert;
   logic [EVT_W-1:0]  severe_events;

   ecsu_gen2 dut (
      .CLK(CLK), .RST_N(RST_N), .sensor_valid(sensor_valid),
      .thunderstorm(thunderstorm), .wind(wind), .visibility(visibility),
      .temperature(temperature), .alert_ack(alert_ack),
      .ECSU_state(ECSU_state), .severe_weather(severe_weather),
      .emergency_landing_alert(emergency_landing_alert),
      .severe_events(severe_events)
   );

   always #5 CLK = ~CLK;

   typedef struct { int st; int ev; } exp_t;
   exp_t exp_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state (plain integers, from the behavioural rules)
   int m_st  = 0;
   int m_cnt = 0;
   int m_ev  = 0;

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int classify(input bit th, input int w, input int vis, input int t);
      if (t > 40 || t < -40 || w > 20) return 3;
      if (th || t > 35 || t < -35 || w > 15 || vis == 3) return 2;
      if (w > 10 || vis == 1 || vis == 2) return 1;
      return 0;
   endfunction

   task automatic model_step();
      int lv, prev;
      if (!sensor_valid) return;
      lv   = classify(thunderstorm, int'(wind), int'(visibility), int'($signed(temperature)));
      prev = m_st;
      if (m_st == 3) begin
         if (alert_ack && lv <= 2) m_st = 2;
         m_cnt = 0;
      end else if (lv > m_st) begin
         m_st = lv; m_cnt = 0;
      end else if (lv == m_st) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt >= PERSIST) begin m_st--; m_cnt = 0; end
      end
`ifdef ECSU_EVENT_CNT_EN
      if (prev < 2 && m_st >= 2 && m_ev < (1 << EVT_W) - 1) m_ev++;
`endif
   endtask

   // Apply one sample across one rising edge; expected response queued.
   task automatic drive(input bit v, input bit th, input int w, input int vis,
                        input int t, input bit ack);
      exp_t e;
      sensor_valid = v; thunderstorm = th; wind = WIND_W'(w);
      visibility = 2'(vis); temperature = TEMP_W'(t); alert_ack = ack;
      @(posedge CLK);
      model_step();
      e.st = m_st; e.ev = m_ev;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic clear(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 20, 0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset();
      @(negedge CLK); #1;
      RST_N = 1'b0;
      #1;
      check("rst_state", int'(ECSU_state), 0);
      check("rst_severe", int'(severe_weather), 0);
      check("rst_emerg", int'(emergency_landing_alert), 0);
      check("rst_events", int'(severe_events), 0);
      m_st = 0; m_cnt = 0; m_ev = 0;
      #2;
      RST_N = 1'b1;
      @(posedge CLK); #1;
   endtask

   // Monitor: outputs are registered, so every edge presents a response.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("state", int'(ECSU_state), e.st);
         check("severe_weather", int'(severe_weather), (e.st >= 2) ? 1 : 0);
         check("emerg_alert", int'(emergency_landing_alert), (e.st == 3) ? 1 : 0);
         check("severe_events", int'(severe_events), e.ev);
      end
   end

   initial begin
      int bnd[8] = '{-41, -40, -36, -35, 35, 36, 40, 41};
      RST_N = 1'b0; sensor_valid = 0; thunderstorm = 0; wind = '0;
      visibility = '0; temperature = '0; alert_ack = 0;
      #12;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      do_reset();

      // caution from wind 12
      drive(1, 0, 12, 0, 20, 0);
      // level skip 0 -> 3
      do_reset();
      drive(1, 0, 25, 0, 20, 0);
      // ack ignored while still emergency, then accepted
      drive(1, 0, 0, 0, 45, 1);
      drive(1, 0, 0, 0, 38, 1);
      // persistence window spanning invalid cycles, then step to 0
      clear(3);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 20, 0);
      clear(1);
      clear(4);
      // signed temperature boundaries
      drive(1, 0, 0, 0, -36, 0);
      drive(1, 0, 0, 0, -35, 0);
      drive(1, 0, 0, 0, -41, 0);
      drive(1, 0, 0, 0, -35, 0);
      drive(1, 0, 0, 0, -35, 1);
      // ack without sensor_valid must be ignored
      drive(1, 0, 25, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 1);
      // reset mid-window in SEVERE, then clear samples stay NORMAL
      do_reset();
      drive(1, 1, 0, 0, 20, 0);
      clear(2);
      do_reset();
      clear(3);

      // randomized run
      for (int i = 0; i < 3000; i++) begin
         int t;
         if ($urandom_range(0, 2) == 0) t = bnd[$urandom_range(0, 7)];
         else t = int'($signed(8'($urandom)));
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
               ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 25)) : int'($urandom_range(0, 10)),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0,
               ($urandom_range(0, 1) == 0) ? t : int'($urandom_range(0, 30)),
               $urandom_range(0, 2) == 0);
      end

      @(negedge CLK); #1;
      if (exp_q.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
